// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Shared types and counter-index constants for the
//               performance-monitor unit.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

  // Monitor sequencing: arm -> count -> dump -> finished
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Fixed positions in the counter bank; event counters follow CNT_EVT_BASE
  localparam int CNT_CYCLE    = 0;
  localparam int CNT_INSN     = 1;
  localparam int CNT_EVT_BASE = 2;

endpackage
`default_nettype wire

// File: rtl/perf_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : perf_sat_counter
// Description : Saturating up-counter with synchronous clear and a sticky
//               overflow flag raised when an increment hits all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  // Clear wins over increment; at all-ones the value holds and ovf latches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&value) begin
        ovf <= 1'b1;
      end else begin
        value <= value + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/perf_counter_unit.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_unit
// Description : Performance monitor: cycle, retired-instruction and NUM_EVT
//               event counters, armed by i_start, stopped by a retiring
//               instruction at a halt PC, then dumped word by word over a
//               valid/ready port.
//               Optional build macro PERF_CYCLE_LIMIT_EN adds MAX_CYCLES and
//               o_timeout: the run is cut off after MAX_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int             NUM_EVT  = 2,
  parameter int             CNT_W    = 32,
  parameter int             PC_W     = 32,
  parameter logic [PC_W-1:0] HALT_PC0 = 32'h1c,
  parameter logic [PC_W-1:0] HALT_PC1 = 32'h20
`ifdef PERF_CYCLE_LIMIT_EN
  , parameter int           MAX_CYCLES = 1_000_000
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_insn_vld,
  input  logic [PC_W-1:0]               i_pc,
  input  logic [NUM_EVT-1:0]            i_evt,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_rd_valid,
  input  logic                          i_rd_ready,
  output logic [$clog2(NUM_EVT+2)-1:0]  o_rd_idx,
  output logic [CNT_W-1:0]              o_rd_data,
  output logic [NUM_EVT+1:0]            o_ovf
`ifdef PERF_CYCLE_LIMIT_EN
  , output logic                        o_timeout
`endif
);

  localparam int               NUM_CNT  = NUM_EVT + 2;
  localparam int               IDX_W    = $clog2(NUM_CNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  state_t             state;
  logic               run;
  logic               start_ok;
  logic               halt;
  logic               limit_hit;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt_val [NUM_CNT];

  // Per-cycle decode of the increment enables and the run-stop conditions
  always_comb begin
    run      = (state == RUN);
    start_ok = i_start && ((state == IDLE) || (state == DONE));
    halt     = run && i_insn_vld && ((i_pc == HALT_PC0) || (i_pc == HALT_PC1));
    inc      = '0;
    inc[CNT_CYCLE] = run;
    inc[CNT_INSN]  = run && i_insn_vld;
    for (int k = 0; k < NUM_EVT; k++) begin
      inc[CNT_EVT_BASE + k] = run && i_evt[k];
    end
`ifdef PERF_CYCLE_LIMIT_EN
    // The limiting increment itself is counted, so the dump shows MAX_CYCLES
    limit_hit = run && !halt && (cnt_val[CNT_CYCLE] == CNT_W'(MAX_CYCLES - 1));
`else
    limit_hit = 1'b0;
`endif
  end

  // One saturating counter per monitored quantity
  generate
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      perf_sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk     (i_clk),
        .reset_n (i_reset),
        .clr     (start_ok),
        .inc     (inc[i]),
        .value   (cnt_val[i]),
        .ovf     (o_ovf[i])
      );
    end
  endgenerate

  // Sequencer with registered status/handshake outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_idx   <= '0;
`ifdef PERF_CYCLE_LIMIT_EN
      o_timeout  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state  <= RUN;
            o_busy <= 1'b1;
            o_done <= 1'b0;
`ifdef PERF_CYCLE_LIMIT_EN
            o_timeout <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (halt || limit_hit) begin
            state      <= DUMP;
            o_rd_valid <= 1'b1;
            o_rd_idx   <= '0;
`ifdef PERF_CYCLE_LIMIT_EN
            if (limit_hit) begin
              o_timeout <= 1'b1;
            end
`endif
          end
        end
        DUMP: begin
          if (i_rd_ready) begin
            if (o_rd_idx == LAST_IDX) begin
              state      <= DONE;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              o_rd_valid <= 1'b0;
              o_rd_idx   <= '0;
            end else begin
              o_rd_idx <= o_rd_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Dump word: counters are frozen during DUMP, so selecting by the
  // registered index yields a stable value until the word is accepted
  always_comb begin
    o_rd_data = '0;
    if (o_rd_valid) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (o_rd_idx == IDX_W'(i)) begin
          o_rd_data = cnt_val[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
Synthesizable, parametrised performance-monitor unit for the pipelined core. It replaces simulation-only cycle/instruction/branch tallies with hardware counters: a cycle counter, a retired-instruction counter and NUM_EVT generic event counters (e.g. ctrl, mispred). Counting is armed by a start pulse and stops when a retiring instruction hits a halt PC. All counters are then dumped one word at a time over a valid/ready port to a bench or debug bridge.

Parameters:
NUM_EVT, 2, number of generic event inputs (bit 0 = ctrl, bit 1 = mispred in the core instance)
CNT_W, 32, width of every counter; counters saturate
PC_W, 32, PC width
HALT_PC0, 32'h1c, first halt address
HALT_PC1, 32'h20, second halt address

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  reset, synchronous, active-low
i_start  in  1  pulse; clears counters and arms counting (honoured in IDLE/DONE only)
i_insn_vld  in  1  instruction retiring this cycle
i_pc  in  PC_W  PC of retiring instruction
i_evt  in  NUM_EVT  per-cycle event strobes
o_busy  out  1  high in RUN and DUMP
o_done  out  1  high in DONE
o_rd_valid  out  1  dump word valid
i_rd_ready  in  1  consumer accepts dump word
o_rd_idx  out  $clog2(NUM_EVT+2)  counter index of o_rd_data
o_rd_data  out  CNT_W  counter value; 0 when o_rd_valid=0
o_ovf  out  NUM_EVT+2  sticky saturation flag per counter

Behaviour:
- NUM_CNT = NUM_EVT+2. Index 0 = cycles, 1 = instructions, 2+k = i_evt[k].
- Reset (i_reset=0 at a clock edge): state IDLE, all counters 0, o_ovf 0, o_busy/o_done/o_rd_valid 0, o_rd_idx 0, o_rd_data 0. Reset overrides every other input in every state, including mid-RUN and mid-DUMP.
- IDLE: counters hold. i_start=1 -> counters and o_ovf cleared, state RUN on the next cycle. The start cycle itself is not counted.
- RUN, every cycle:
  - cycle counter +1;
  - instruction counter +1 if i_insn_vld;
  - counter 2+k +1 if i_evt[k].
  - Halt condition: i_insn_vld && (i_pc==HALT_PC0 || i_pc==HALT_PC1). The halt cycle is counted (inclusive), then state DUMP with o_rd_idx=0. i_start is ignored.
- Saturation: a counter at all-ones stays at all-ones on further increments and sets its o_ovf bit. The bit is cleared only by reset or start.
- DUMP: o_rd_valid=1, o_rd_idx=idx, o_rd_data=counter[idx], registered and stable while not accepted.
  - Transfer on o_rd_valid && i_rd_ready: idx+1 on the next cycle.
  - Transfer at idx==NUM_CNT-1 -> DONE next cycle, o_rd_valid=0.
  - Counters are frozen; i_start, events and halt are ignored.
- DONE: o_done=1, counters keep their values. i_start -> clear and RUN, same as from IDLE.
- States are exclusive; o_busy = RUN|DUMP.

Optional Feature:
PERF_CYCLE_LIMIT_EN
- Defined: adds parameter MAX_CYCLES (default 1_000_000) and output o_timeout (1 bit, reset 0).
  - In RUN, if the cycle counter equals MAX_CYCLES-1 and is about to increment without a halt, it increments to MAX_CYCLES, the state goes to DUMP and o_timeout sets.
  - o_timeout is sticky until reset or start.
  - A halt in the same cycle takes priority: o_timeout stays 0.
- Undefined: no limit, no o_timeout port.

Decomposition:
- perf_pkg: state enum (IDLE, RUN, DUMP, DONE), constants CNT_CYCLE=0, CNT_INSN=1, CNT_EVT_BASE=2.
- Sub-module perf_sat_counter (CNT_W): synchronous clear, increment enable, saturating value, sticky ovf. Instantiated NUM_CNT times in a generate loop.

Test Plan:
1. Reset, start, 10 RUN cycles with i_insn_vld=1, i_evt[0] high on 3 cycles, i_pc=0x1c on cycle 10, i_rd_ready=1 -> dump (0,10),(1,10),(2,3),(3,0), then o_done=1, o_ovf=0.
2. Scenario 1 with i_rd_ready low for 5 cycles at idx 1 -> o_rd_valid stays 1, o_rd_idx=1, o_rd_data=10 stable; idx advances only after ready.
3. CNT_W=4, 20 RUN cycles with insn_vld=1, then halt -> cycles=15, insn=15, o_ovf[1:0]=2'b11, o_ovf[3:2]=0.
4. i_pc=0x20 with i_insn_vld=0 -> no halt; next cycle i_pc=0x20 with i_insn_vld=1 -> DUMP, halt cycle included in the counts.
5. Reset asserted mid-DUMP at idx 2 -> next cycle IDLE, o_rd_valid=0, all counters 0. i_start in RUN changes nothing. i_start in DONE restarts with counters cleared.
6. PERF_CYCLE_LIMIT_EN with MAX_CYCLES=8, no halt -> DUMP entered with cycle count 8, o_timeout=1. Repeat with halt on cycle 8 -> o_timeout=0.
